// File: rtl/sdram_port_arb.sv
// Two-port arbiter in front of a single-command SDRAM controller.
// One transaction in flight at a time; a BUSY watchdog aborts hung transfers and raises a sticky error.
module sdram_port_arb #(
    parameter int RR_EN = 1,
    parameter int TMO   = 255
) (
    input  logic        clk_p,
    input  logic        sdram_reset,
    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic [1:0]  m0_sel,
    input  logic [20:0] m0_adr,
    input  logic [15:0] m0_out,
    output logic        m0_ack,
    output logic [15:0] m0_dat,
    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic [1:0]  m1_sel,
    input  logic [20:0] m1_adr,
    input  logic [15:0] m1_out,
    output logic        m1_ack,
    output logic [15:0] m1_dat,
    input  logic        sdram_ready,
    output logic        sdr_rd,
    output logic        sdr_we,
    output logic [1:0]  sdr_wtbt,
    output logic [24:0] sdr_addr,
    output logic [15:0] sdr_din,
    input  logic [15:0] sdr_dout,
    input  logic        sdr_ack,
    output logic        err_tmo
);

    localparam logic [7:0] TMO_LIM = 8'(TMO);
    localparam logic [7:0] TMO_HIT = 8'(TMO - 1);

    // IDLE arbitrate | ISSUE one-cycle command | BUSY wait for ack 0->1 | DONE ack pulse
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        gnt_q, gnt_d;
    logic        we_q, we_d;
    logic [1:0]  sel_q, sel_d;
    logic [20:0] adr_q, adr_d;
    logic [15:0] wdat_q, wdat_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic [15:0] dat0_q, dat0_d;
    logic [15:0] dat1_q, dat1_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        seen_low_q, seen_low_d;
    logic        keep_q, keep_d;
    logic        err_q, err_d;

    logic        pick;
    logic        cur_stb;
    logic        finish;
    logic        timeout;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        we_d       = we_q;
        sel_d      = sel_q;
        adr_d      = adr_q;
        wdat_d     = wdat_q;
        rd_d       = 1'b0;
        wr_d       = 1'b0;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        dat0_d     = dat0_q;
        dat1_d     = dat1_q;
        cnt_d      = cnt_q;
        seen_low_d = seen_low_q;
        keep_d     = keep_q;
        err_d      = err_q;
        finish     = 1'b0;
        timeout    = 1'b0;

        if (m0_stb && m1_stb) begin
            pick = (RR_EN != 0) ? ~last_q : 1'b0;
        end else begin
            pick = m1_stb;
        end
        cur_stb = gnt_q ? m1_stb : m0_stb;

        unique case (state_q)
            S_IDLE: begin
                if (sdram_ready && (m0_stb || m1_stb)) begin
                    gnt_d      = pick;
                    last_d     = pick;
                    we_d       = pick ? m1_we  : m0_we;
                    sel_d      = pick ? m1_sel : m0_sel;
                    adr_d      = pick ? m1_adr : m0_adr;
                    wdat_d     = pick ? m1_out : m0_out;
                    rd_d       = ~we_d;
                    wr_d       = we_d;
                    keep_d     = 1'b1;
                    cnt_d      = 8'd0;
                    seen_low_d = 1'b0;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!cur_stb) keep_d = 1'b0;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                // A requester that lets go of stb still gets its transfer, just no ack.
                if (!cur_stb) keep_d = 1'b0;
                if (sdr_ack && seen_low_q) begin
                    finish = 1'b1;
                end else if (cnt_q == TMO_HIT) begin
                    finish  = 1'b1;
                    timeout = 1'b1;
                end else begin
                    if (cnt_q != TMO_LIM) cnt_d = cnt_q + 8'd1;
                    if (!sdr_ack) seen_low_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (finish) begin
            state_d = S_DONE;
            if (timeout) err_d = 1'b1;
            if (gnt_q) begin
                ack1_d = keep_q & m1_stb;
                if (!we_q) dat1_d = timeout ? 16'hFFFF : sdr_dout;
            end else begin
                ack0_d = keep_q & m0_stb;
                if (!we_q) dat0_d = timeout ? 16'hFFFF : sdr_dout;
            end
        end
    end

    always_ff @(posedge clk_p) begin
        if (sdram_reset) begin
            state_q    <= S_IDLE;
            last_q     <= 1'b1;
            gnt_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= 2'b00;
            adr_q      <= 21'd0;
            wdat_q     <= 16'd0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            dat0_q     <= 16'd0;
            dat1_q     <= 16'd0;
            cnt_q      <= 8'd0;
            seen_low_q <= 1'b0;
            keep_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            adr_q      <= adr_d;
            wdat_q     <= wdat_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            dat0_q     <= dat0_d;
            dat1_q     <= dat1_d;
            cnt_q      <= cnt_d;
            seen_low_q <= seen_low_d;
            keep_q     <= keep_d;
            err_q      <= err_d;
        end
    end

    assign sdr_rd   = rd_q;
    assign sdr_we   = wr_q;
    assign sdr_wtbt = sel_q;
    assign sdr_addr = {3'b000, adr_q, 1'b0};
    assign sdr_din  = wdat_q;
    assign m0_ack   = ack0_q;
    assign m1_ack   = ack1_q;
    assign m0_dat   = dat0_q;
    assign m1_dat   = dat1_q;
    assign err_tmo  = err_q;

endmodule

// File: tb/tb_sdram_port_arb.sv
// Scoreboard bench for sdram_port_arb: stimulus pushes expected commands/acks, monitors pop and compare.
module tb_sdram_port_arb;

    logic clk_p = 1'b0;
    always #5 clk_p = ~clk_p;

    logic        sdram_reset;
    logic        sdram_ready;
    logic        stb [2];
    logic        we [2];
    logic [1:0]  sel [2];
    logic [20:0] adr [2];
    logic [15:0] wdat [2];
    logic        ack_o [2];
    logic [15:0] dat_o [2];
    logic        sdr_rd, sdr_we;
    logic [1:0]  sdr_wtbt;
    logic [24:0] sdr_addr;
    logic [15:0] sdr_din, sdr_dout;
    logic        sdr_ack, err_tmo;

    logic        fstb [2];
    logic        fack [2];
    logic [15:0] fdat [2];
    logic        f_rd, f_we;
    logic [1:0]  f_wtbt;
    logic [24:0] f_addr;
    logic [15:0] f_din;
    logic        f_sdr_ack, f_err;

    sdram_port_arb #(.RR_EN(1), .TMO(255)) dut (
        .clk_p(clk_p), .sdram_reset(sdram_reset),
        .m0_stb(stb[0]), .m0_we(we[0]), .m0_sel(sel[0]), .m0_adr(adr[0]), .m0_out(wdat[0]),
        .m0_ack(ack_o[0]), .m0_dat(dat_o[0]),
        .m1_stb(stb[1]), .m1_we(we[1]), .m1_sel(sel[1]), .m1_adr(adr[1]), .m1_out(wdat[1]),
        .m1_ack(ack_o[1]), .m1_dat(dat_o[1]),
        .sdram_ready(sdram_ready), .sdr_rd(sdr_rd), .sdr_we(sdr_we), .sdr_wtbt(sdr_wtbt),
        .sdr_addr(sdr_addr), .sdr_din(sdr_din), .sdr_dout(sdr_dout), .sdr_ack(sdr_ack),
        .err_tmo(err_tmo)
    );

    sdram_port_arb #(.RR_EN(0), .TMO(255)) dut_fp (
        .clk_p(clk_p), .sdram_reset(sdram_reset),
        .m0_stb(fstb[0]), .m0_we(we[0]), .m0_sel(sel[0]), .m0_adr(adr[0]), .m0_out(wdat[0]),
        .m0_ack(fack[0]), .m0_dat(fdat[0]),
        .m1_stb(fstb[1]), .m1_we(we[1]), .m1_sel(sel[1]), .m1_adr(adr[1]), .m1_out(wdat[1]),
        .m1_ack(fack[1]), .m1_dat(fdat[1]),
        .sdram_ready(sdram_ready), .sdr_rd(f_rd), .sdr_we(f_we), .sdr_wtbt(f_wtbt),
        .sdr_addr(f_addr), .sdr_din(f_din), .sdr_dout(sdr_dout), .sdr_ack(f_sdr_ack),
        .err_tmo(f_err)
    );

    typedef struct {
        logic        w;
        logic [24:0] addr;
        logic [1:0]  wtbt;
        logic [15:0] din;
    } cmd_t;

    typedef struct {
        int          port;
        logic        rd;
        logic [15:0] dat;
    } ack_t;

    cmd_t cmd_q[$];
    ack_t ack_q[$];
    int   fexp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cmd_seen = 0;
    int ack_seen = 0;

    int ctl_lat = 5;
    bit ctl_hold = 1'b0;
    int ctl_cnt = 0;
    int f_cnt = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Controller models: drop ack for ctl_lat cycles after each command.
    initial begin
        sdr_ack = 1'b1;
        forever begin
            @(negedge clk_p);
            if (sdram_reset || ctl_hold) begin
                sdr_ack = 1'b1;
                ctl_cnt = 0;
            end else if (sdr_rd || sdr_we) begin
                sdr_ack = 1'b0;
                ctl_cnt = ctl_lat;
            end else if (ctl_cnt > 0) begin
                ctl_cnt--;
                if (ctl_cnt == 0) sdr_ack = 1'b1;
            end
        end
    end

    initial begin
        f_sdr_ack = 1'b1;
        forever begin
            @(negedge clk_p);
            if (sdram_reset) begin
                f_sdr_ack = 1'b1;
                f_cnt = 0;
            end else if (f_rd || f_we) begin
                f_sdr_ack = 1'b0;
                f_cnt = 3;
            end else if (f_cnt > 0) begin
                f_cnt--;
                if (f_cnt == 0) f_sdr_ack = 1'b1;
            end
        end
    end

    logic prev_cmd = 1'b0;
    logic prev_ack0 = 1'b0;
    logic prev_ack1 = 1'b0;

    always @(negedge clk_p) begin
        cmd_t c;
        ack_t a;
        if (sdram_reset) begin
            prev_cmd = 1'b0;
            prev_ack0 = 1'b0;
            prev_ack1 = 1'b0;
        end else begin
            if (sdr_rd || sdr_we) begin
                cmd_seen++;
                check("cmd_excl", 64'(sdr_rd & sdr_we), 64'(0));
                check("issue_len", 64'(prev_cmd), 64'(0));
                if (cmd_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL cmd_unexpected: actual rd=%0b we=%0b addr=%0h required no command",
                             sdr_rd, sdr_we, sdr_addr);
                end else begin
                    c = cmd_q.pop_front();
                    check("cmd_we", 64'(sdr_we), 64'(c.w));
                    check("cmd_rd", 64'(sdr_rd), 64'(!c.w));
                    check("cmd_addr", 64'(sdr_addr), 64'(c.addr));
                    check("cmd_wtbt", 64'(sdr_wtbt), 64'(c.wtbt));
                    if (c.w) check("cmd_din", 64'(sdr_din), 64'(c.din));
                end
            end
            if (ack_o[0] || ack_o[1]) begin
                ack_seen++;
                check("ack_onehot", 64'(ack_o[0] & ack_o[1]), 64'(0));
                check("ack_len", 64'((ack_o[0] & prev_ack0) | (ack_o[1] & prev_ack1)), 64'(0));
                if (ack_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL ack_unexpected: actual ack0=%0b ack1=%0b required no ack",
                             ack_o[0], ack_o[1]);
                end else begin
                    a = ack_q.pop_front();
                    check("ack_port", 64'(ack_o[1]), 64'(a.port));
                    if (a.rd) check("ack_dat", 64'(dat_o[a.port]), 64'(a.dat));
                end
            end
            prev_cmd = sdr_rd | sdr_we;
            prev_ack0 = ack_o[0];
            prev_ack1 = ack_o[1];
        end
    end

    always @(negedge clk_p) begin
        int p;
        if (!sdram_reset) begin
            if (f_rd || f_we) check("fp_excl", 64'(f_rd & f_we), 64'(0));
            if (fack[0] || fack[1]) begin
                if (fexp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL fp_ack_unexpected: actual ack0=%0b ack1=%0b required no ack",
                             fack[0], fack[1]);
                end else begin
                    p = fexp_q.pop_front();
                    check("fp_order", 64'(fack[1]), 64'(p));
                end
            end
        end
    end

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk_p);
    endtask

    task automatic check_reset_vals(input string pre);
        check({pre, "_rd"},   64'(sdr_rd),   64'(0));
        check({pre, "_we"},   64'(sdr_we),   64'(0));
        check({pre, "_ack0"}, 64'(ack_o[0]), 64'(0));
        check({pre, "_ack1"}, 64'(ack_o[1]), 64'(0));
        check({pre, "_dat0"}, 64'(dat_o[0]), 64'(0));
        check({pre, "_dat1"}, 64'(dat_o[1]), 64'(0));
        check({pre, "_wtbt"}, 64'(sdr_wtbt), 64'(0));
        check({pre, "_addr"}, 64'(sdr_addr), 64'(0));
        check({pre, "_din"},  64'(sdr_din),  64'(0));
        check({pre, "_err"},  64'(err_tmo),  64'(0));
    endtask

    task automatic expect_txn(input int p, input logic w, input logic [1:0] s, input logic [15:0] d,
                              input logic [24:0] exp_addr, input logic [15:0] rd_dat, input bit with_ack);
        cmd_t c;
        ack_t a;
        c.w = w;
        c.addr = exp_addr;
        c.wtbt = s;
        c.din = d;
        cmd_q.push_back(c);
        if (with_ack) begin
            a.port = p;
            a.rd = !w;
            a.dat = rd_dat;
            ack_q.push_back(a);
        end
    endtask

    task automatic drive_port(input int p, input logic w, input logic [1:0] s,
                              input logic [20:0] a, input logic [15:0] d);
        we[p] = w;
        sel[p] = s;
        adr[p] = a;
        wdat[p] = d;
        stb[p] = 1'b1;
    endtask

    task automatic wait_ack(input int p, input int bound, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk_p);
            cyc++;
        end while (!ack_o[p] && cyc < bound);
        if (!ack_o[p]) begin
            n_cmp++;
            n_err++;
            $display("FAIL ack_wait_port%0d: actual no ack after %0d cycles required ack", p, cyc);
        end
    endtask

    task automatic run_txn(input int p, input logic w, input logic [1:0] s,
                           input logic [20:0] a, input logic [15:0] d, output int cyc);
        drive_port(p, w, s, a, d);
        wait_ack(p, 400, cyc);
        stb[p] = 1'b0;
    endtask

    task automatic port_seq(input int p);
        int c;
        for (int k = 0; k < 3; k++) begin
            drive_port(p, 1'b1, 2'b11, (p == 0 ? 21'h10 : 21'h20) + 21'(k),
                       (p == 0 ? 16'hA000 : 16'hB000) + 16'(k));
            wait_ack(p, 100, c);
        end
        stb[p] = 1'b0;
    endtask

    task automatic fport_seq(input int p);
        int c;
        for (int k = 0; k < 3; k++) begin
            we[p] = 1'b1;
            sel[p] = 2'b11;
            adr[p] = 21'h40 + 21'(k);
            wdat[p] = 16'hC000 + 16'(k);
            fstb[p] = 1'b1;
            c = 0;
            do begin
                @(negedge clk_p);
                c++;
            end while (!fack[p] && c < 100);
            if (!fack[p]) begin
                n_cmp++;
                n_err++;
                $display("FAIL fp_ack_wait_port%0d: actual no ack after %0d cycles required ack", p, c);
            end
        end
        fstb[p] = 1'b0;
    endtask

    logic [24:0] rr_addr0 [3] = '{25'h0000020, 25'h0000022, 25'h0000024};
    logic [24:0] rr_addr1 [3] = '{25'h0000040, 25'h0000042, 25'h0000044};

    initial begin
        int cyc;
        int base_cmd;
        int base_ack;
        sdram_reset = 1'b1;
        sdram_ready = 1'b1;
        sdr_dout = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            stb[i] = 1'b0;
            we[i] = 1'b0;
            sel[i] = 2'b00;
            adr[i] = 21'd0;
            wdat[i] = 16'd0;
            fstb[i] = 1'b0;
        end
        clk_n(3);
        check_reset_vals("rst");
        sdram_reset = 1'b0;
        clk_n(2);

        // Port 0 read with a 5-cycle controller busy time.
        sdr_dout = 16'h1234;
        ctl_lat = 5;
        expect_txn(0, 1'b0, 2'b11, 16'h0, 25'h0000200, 16'h1234, 1'b1);
        run_txn(0, 1'b0, 2'b11, 21'h000100, 16'h0, cyc);
        check("rd_latency", 64'(cyc), 64'(7));
        clk_n(3);
        check("m0_dat_hold", 64'(dat_o[0]), 64'(16'h1234));

        // Port 1 byte-masked write at the top address.
        sdr_dout = 16'h9999;
        expect_txn(1, 1'b1, 2'b10, 16'hABCD, 25'h03FFFFE, 16'h0, 1'b1);
        run_txn(1, 1'b1, 2'b10, 21'h1FFFFF, 16'hABCD, cyc);
        check("wr_latency", 64'(cyc), 64'(7));
        clk_n(2);
        check("m1_dat_after_write", 64'(dat_o[1]), 64'(0));
        check("m0_dat_hold2", 64'(dat_o[0]), 64'(16'h1234));

        // Port 1 read with short busy time.
        sdr_dout = 16'h5A5A;
        ctl_lat = 2;
        expect_txn(1, 1'b0, 2'b01, 16'h0, 25'h01579BC, 16'h5A5A, 1'b1);
        run_txn(1, 1'b0, 2'b01, 21'h0ABCDE, 16'h0, cyc);
        check("rd1_latency", 64'(cyc), 64'(4));
        clk_n(2);
        check("m1_dat_read", 64'(dat_o[1]), 64'(16'h5A5A));
        check("m0_dat_hold3", 64'(dat_o[0]), 64'(16'h1234));

        // Round-robin: simultaneous writers alternate 0,1,0,1,0,1.
        sdram_reset = 1'b1;
        clk_n(2);
        sdram_reset = 1'b0;
        ctl_lat = 3;
        for (int k = 0; k < 3; k++) begin
            expect_txn(0, 1'b1, 2'b11, 16'hA000 + 16'(k), rr_addr0[k], 16'h0, 1'b1);
            expect_txn(1, 1'b1, 2'b11, 16'hB000 + 16'(k), rr_addr1[k], 16'h0, 1'b1);
        end
        fork
            port_seq(0);
            port_seq(1);
        join
        clk_n(3);

        // Requester drops stb mid-transfer: write still issued, no ack.
        base_ack = ack_seen;
        expect_txn(0, 1'b1, 2'b01, 16'h55AA, 25'h00000AA, 16'h0, 1'b0);
        drive_port(0, 1'b1, 2'b01, 21'h000055, 16'h55AA);
        clk_n(3);
        stb[0] = 1'b0;
        clk_n(ctl_lat + 6);
        check("drop_cmd_issued", 64'(cmd_q.size()), 64'(0));
        check("drop_no_ack", 64'(ack_seen - base_ack), 64'(0));

        // Controller not ready: no command until sdram_ready rises.
        sdram_ready = 1'b0;
        sdr_dout = 16'h0F0F;
        base_cmd = cmd_seen;
        drive_port(0, 1'b0, 2'b11, 21'h000300, 16'h0);
        clk_n(20);
        check("not_ready_no_cmd", 64'(cmd_seen - base_cmd), 64'(0));
        expect_txn(0, 1'b0, 2'b11, 16'h0, 25'h0000600, 16'h0F0F, 1'b1);
        sdram_ready = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk_p);
            cyc++;
        end while (!sdr_rd && cyc < 5);
        check("ready_issue_delay", 64'(cyc >= 1 && cyc <= 2), 64'(1));
        wait_ack(0, 50, cyc);
        stb[0] = 1'b0;
        clk_n(2);

        // Controller ack stuck high: watchdog aborts after TMO busy cycles.
        ctl_hold = 1'b1;
        sdr_dout = 16'h4321;
        check("err_before_tmo", 64'(err_tmo), 64'(0));
        expect_txn(0, 1'b0, 2'b11, 16'h0, 25'h0000002, 16'hFFFF, 1'b1);
        run_txn(0, 1'b0, 2'b11, 21'h000001, 16'h0, cyc);
        check("tmo_latency", 64'(cyc), 64'(257));
        check("err_tmo_set", 64'(err_tmo), 64'(1));
        ctl_hold = 1'b0;
        clk_n(5);
        sdr_dout = 16'h7777;
        ctl_lat = 2;
        expect_txn(1, 1'b0, 2'b11, 16'h0, 25'h0000010, 16'h7777, 1'b1);
        run_txn(1, 1'b0, 2'b11, 21'h000008, 16'h0, cyc);
        clk_n(3);
        check("err_tmo_sticky", 64'(err_tmo), 64'(1));
        check("m0_dat_tmo_hold", 64'(dat_o[0]), 64'(16'hFFFF));
        sdram_reset = 1'b1;
        clk_n(1);
        check_reset_vals("rst_tmo");
        sdram_reset = 1'b0;
        clk_n(2);

        // Reset in BUSY abandons the transfer without an ack.
        ctl_lat = 10;
        sdr_dout = 16'h2222;
        base_ack = ack_seen;
        expect_txn(0, 1'b0, 2'b11, 16'h0, 25'h0000800, 16'h0, 1'b0);
        drive_port(0, 1'b0, 2'b11, 21'h000400, 16'h0);
        clk_n(4);
        sdram_reset = 1'b1;
        stb[0] = 1'b0;
        clk_n(1);
        check_reset_vals("rst_busy");
        sdram_reset = 1'b0;
        clk_n(12);
        check("rst_busy_no_ack", 64'(ack_seen - base_ack), 64'(0));
        ctl_lat = 3;
        sdr_dout = 16'hBEEF;
        expect_txn(0, 1'b0, 2'b11, 16'h0, 25'h0000802, 16'hBEEF, 1'b1);
        run_txn(0, 1'b0, 2'b11, 21'h000401, 16'h0, cyc);
        check("post_rst_latency", 64'(cyc), 64'(5));
        clk_n(3);

        // Fixed-priority instance: port 0 wins while it keeps requesting.
        sdram_reset = 1'b1;
        clk_n(2);
        sdram_reset = 1'b0;
        fexp_q.push_back(0);
        fexp_q.push_back(0);
        fexp_q.push_back(0);
        fexp_q.push_back(1);
        fexp_q.push_back(1);
        fexp_q.push_back(1);
        fork
            fport_seq(0);
            fport_seq(1);
        join
        clk_n(5);

        check("cmd_q_drained", 64'(cmd_q.size()), 64'(0));
        check("ack_q_drained", 64'(ack_q.size()), 64'(0));
        check("fp_q_drained", 64'(fexp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual simulation still running required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
